// File: rtl/cpu19_pkg.sv
// Shared CPU19 definitions: loader state encoding and default word/address widths,
// common to the program loader and the CPU core.
package cpu19_pkg;
  localparam int CPU_DATA_W = 19;
  localparam int CPU_ADDR_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;
endpackage

// File: rtl/cpu_prog_loader.sv
// Program loader: holds the CPU in reset, streams a word block into memory with one registered
// write per handshake (1-cycle latency), then releases the CPU; in_ready is high only while loading.
module cpu_prog_loader
  import cpu19_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(1) << ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W+1:0] load_end;
  logic              range_bad;

  // Two guard bits so start_addr + load_len cannot overflow before the compare.
  always_comb begin
    load_end  = {2'b00, start_addr} + {1'b0, load_len};
    range_bad = (load_len == '0) || (load_end > DEPTH);
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            if (range_bad) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              err       <= 1'b0;
              checksum  <= '0;
              addr      <= start_addr;
              remaining <= load_len;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          // Abort wins over a same-cycle handshake, so that word is dropped.
          if (abort) begin
            err      <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (in_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= in_data;
            checksum  <= checksum + in_data;
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          busy <= 1'b0;
          if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            done      <= 1'b1;
            cpu_reset <= 1'b0;
            state     <= RUN;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_prog_loader.sv
// Bench for cpu_prog_loader: directed scenarios plus random traffic against a behavioural model.
module tb_cpu_prog_loader;
  localparam int DW = 19;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk1 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   load_len = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, mem_we, cpu_reset, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, checksum;

  cpu_prog_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk1(clk1), .reset(reset), .start(start), .start_addr(start_addr), .load_len(load_len),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_fail = 0;
  int wr_count = 0;
  int last_wa = -1;
  int mem_bad = 0;
  bit checking = 0;
  int exp_mem[DEPTH];
  int dut_mem[DEPTH];

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase flags, word counter, integer checksum modulo 2^DW.
  bit m_load, m_tail, m_run, m_err, m_we;
  int m_left, m_addr, m_chk, m_wa, m_wd;

  always @(posedge clk1 or posedge reset) begin
    if (reset) begin
      m_load = 0; m_tail = 0; m_run = 0; m_err = 0; m_we = 0;
      m_left = 0; m_chk = 0; m_wa = 0; m_wd = 0;
    end else begin
      if (m_we) exp_mem[m_wa] = m_wd;
      m_we = 0;
      if ((m_load || m_tail) && abort) begin
        m_load = 0; m_tail = 0; m_err = 1;
      end else if (m_load) begin
        if (in_valid) begin
          m_we = 1; m_wa = m_addr; m_wd = int'(in_data);
          m_chk = (m_chk + m_wd) % (1 << DW);
          m_addr++; m_left--;
          if (m_left == 0) begin m_load = 0; m_tail = 1; end
        end
      end else if (m_tail) begin
        m_tail = 0; m_run = 1;
      end else if (start) begin
        m_run = 0;
        if (load_len == 0 || int'(start_addr) + int'(load_len) > DEPTH) m_err = 1;
        else begin
          m_err = 0; m_chk = 0; m_addr = int'(start_addr); m_left = int'(load_len); m_load = 1;
        end
      end
    end
  end

  // The memory itself commits on the rising edge.
  always @(posedge clk1) if (mem_we) dut_mem[mem_addr] <= int'(mem_wdata);

  always @(negedge clk1) begin
    if (checking) begin
      check("cpu_reset", cpu_reset, !m_run);
      check("in_ready", in_ready, m_load);
      check("busy", busy, m_load || m_tail);
      check("done", done, m_run);
      check("err", err, m_err);
      check("checksum", checksum, m_chk);
      check("mem_we", mem_we, m_we);
      if (m_we) begin
        check("mem_addr", mem_addr, m_wa);
        check("mem_wdata", mem_wdata, m_wd);
      end
    end
    if (mem_we) begin
      wr_count++;
      last_wa = int'(mem_addr);
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_start(int a, int n);
    start_addr = AW'(a);
    load_len = (AW+1)'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(int d, bit gap);
    int t = 0;
    in_valid = 1'b1;
    in_data = DW'(d);
    while (!in_ready && t < 100) begin step(); t++; end
    if (t >= 100) check("send_in_ready_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
    if (gap) step();
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin step(); t++; end
    check("wait_done", done, 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = 0; dut_mem[i] = 0; end
    repeat (2) @(posedge clk1);
    #1;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_checksum", checksum, 0);
    reset = 1'b0;
    checking = 1;
    step();

    // Basic three-word load, back to back.
    wr_count = 0;
    do_start(0, 3);
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    check("t1_cpu_reset_load", cpu_reset, 1);
    send(5, 0); send(3, 0); send(8, 0);
    check("t1_drain_cpu_reset", cpu_reset, 1);
    check("t1_drain_we", mem_we, 1);
    step();
    check("t1_run_cpu_reset", cpu_reset, 0);
    check("t1_run_done", done, 1);
    check("t1_checksum", checksum, 16);
    check("t1_mem0", dut_mem[0], 5);
    check("t1_mem1", dut_mem[1], 3);
    check("t1_mem2", dut_mem[2], 8);
    check("t1_writes", wr_count, 3);

    // Same load with gaps, restarted from RUN.
    dut_mem[0] = 0; dut_mem[1] = 0; dut_mem[2] = 0;
    wr_count = 0;
    do_start(0, 3);
    check("t2_cpu_reset_reload", cpu_reset, 1);
    send(5, 1); send(3, 1); send(8, 1);
    wait_done();
    check("t2_checksum", checksum, 16);
    check("t2_mem2", dut_mem[2], 8);
    check("t2_writes", wr_count, 3);

    // Range check at the top of memory.
    wr_count = 0;
    do_start(250, 7);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_cpu_reset", cpu_reset, 1);
    repeat (3) step();
    check("t3_no_writes", wr_count, 0);
    do_start(250, 6);
    check("t3_err_cleared", err, 0);
    for (int i = 0; i < 6; i++) send(i * 7 + 1, i[0]);
    wait_done();
    check("t3_last_addr", last_wa, 255);
    check("t3_mem255", dut_mem[255], 36);
    check("t3_checksum", checksum, 111);

    // Abort on the second handshake.
    wr_count = 0;
    do_start(10, 4);
    send(100, 0);
    in_valid = 1'b1; in_data = DW'(200); abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    check("t4_cpu_reset", cpu_reset, 1);
    step();
    check("t4_writes", wr_count, 1);
    check("t4_mem11_untouched", dut_mem[11], 0);
    do_start(20, 1);
    check("t4_err_cleared", err, 0);
    send(7, 0);
    wait_done();

    // Reload from RUN with an ignored start in the middle.
    do_start(60, 2);
    check("t5_cpu_reset", cpu_reset, 1);
    check("t5_done", done, 0);
    send(1000, 0);
    start_addr = '0; load_len = (AW+1)'(1); start = 1'b1;
    step();
    start = 1'b0;
    check("t5_start_ignored", busy, 1);
    send(2000, 0);
    wait_done();
    check("t5_checksum", checksum, 3000);
    check("t5_mem61", dut_mem[61], 2000);

    // Checksum wraps modulo 2^19.
    do_start(30, 2);
    send(524287, 0); send(2, 0);
    wait_done();
    check("t6_checksum_wrap", checksum, 1);

    // Asynchronous reset mid-load drops the pending write.
    do_start(40, 4);
    send(11, 0); send(12, 0);
    #2 reset = 1'b1;
    #1;
    check("t7_cpu_reset", cpu_reset, 1);
    check("t7_in_ready", in_ready, 0);
    check("t7_mem_we", mem_we, 0);
    check("t7_mem_addr", mem_addr, 0);
    check("t7_busy", busy, 0);
    check("t7_checksum", checksum, 0);
    step();
    reset = 1'b0;
    step();
    check("t7_mem40_kept", dut_mem[40], 11);
    check("t7_mem41_dropped", dut_mem[41], 0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 19) == 0);
      if (start) begin
        start_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(240, 255)) : AW'($urandom_range(0, 255));
        load_len = (AW+1)'($urandom_range(0, 12));
        if ($urandom_range(0, 49) == 0) begin
          load_len = (AW+1)'(256);
          if ($urandom_range(0, 1) == 1) start_addr = '0;
        end
      end
      abort = ($urandom_range(0, 59) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data = DW'($urandom);
      step();
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    repeat (3) step();

    for (int i = 0; i < DEPTH; i++) if (exp_mem[i] != dut_mem[i]) mem_bad++;
    check("mem_image_mismatches", mem_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
